// File: rtl/rop3_pkg.sv
// rop3_pkg
//   Shared definitions for the ROP3 result packer slice.
//   - ROP3_N / ROP3_PACK / ROP3_DEPTH : default pixel width, pixels per word
//     and word-FIFO depth.
//   - rop3_entry_t : one FIFO entry {last, keep[PACK], data[N*PACK]} at the
//     default sizes.
//   - entry_width() : flattened entry width for any N/PACK.
package rop3_pkg;

    localparam int ROP3_N     = 8;
    localparam int ROP3_PACK  = 4;
    localparam int ROP3_DEPTH = 4;

    typedef struct packed {
        logic                          last;
        logic [ROP3_PACK-1:0]          keep;
        logic [ROP3_N*ROP3_PACK-1:0]   data;
    } rop3_entry_t;

    function automatic int entry_width(input int n, input int pack);
        return 1 + pack + n * pack;
    endfunction

endpackage

// File: rtl/rop3_word_fifo.sv
// rop3_word_fifo
//   Synchronous DEPTH-entry word FIFO with occupancy count and simultaneous
//   push/pop. Storage is not reset; the head output reads as zero while the
//   FIFO is empty so downstream sees clean values after reset.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers and count)
//   push, din     write one entry (ignored while full)
//   pop           remove the head entry (ignored while empty)
//   dout          head entry, zero when empty
//   count         number of stored entries, 0..DEPTH
//   empty         count == 0
module rop3_word_fifo #(
    parameter  int W     = 37,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full = (r_count == CW'(DEPTH));
    assign empty  = (r_count == '0);
    assign w_push = push && !w_full;
    assign w_pop  = pop && !empty;
    assign count  = r_count;
    assign dout   = empty ? '0 : r_mem[r_rptr];

    // Pointers are log2(DEPTH) bits, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= din;
    end

endmodule

// File: rtl/rop3_result_packer.sv
// rop3_result_packer
//   Packs PACK consecutive N-bit ROP3 result pixels into one wide word,
//   buffers words in a DEPTH-entry FIFO and presents them to the memory-write
//   side. in_last closes a frame, flushing a partial word with a keep mask.
//   Optional frame checksum enabled by defining ROP3_CHECKSUM_EN; without it
//   checksum/checksum_valid are tied to 0.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready  pixel input handshake
//   out_valid/out_data/out_keep/out_last/out_ready  packed word output
//   checksum, checksum_valid         16-bit frame sum, one-cycle update pulse
module rop3_result_packer
    import rop3_pkg::*;
#(
    parameter int N     = ROP3_N,
    parameter int PACK  = ROP3_PACK,
    parameter int DEPTH = ROP3_DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [N-1:0]        in_data,
    input  logic                in_last,
    output logic                in_ready,
    output logic                out_valid,
    output logic [N*PACK-1:0]   out_data,
    output logic [PACK-1:0]     out_keep,
    output logic                out_last,
    input  logic                out_ready,
    output logic [15:0]         checksum,
    output logic                checksum_valid
);

    localparam int LW = $clog2(PACK);
    localparam int EW = entry_width(N, PACK);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LW-1:0]     r_lane;
    logic [N*PACK-1:0] r_hold;
    logic [PACK-1:0]   r_keep;

    logic              w_accept;
    logic              w_flush;
    logic              w_pop;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [N*PACK-1:0] w_word_data;
    logic [PACK-1:0]   w_word_keep;
    logic [EW-1:0]     w_head;

    // Ready depends only on the registered occupancy; no same-cycle pass-through.
    assign in_ready = !rst && (w_count < CW'(DEPTH));
    assign w_accept = in_valid && in_ready;
    assign w_flush  = w_accept && ((r_lane == LW'(PACK - 1)) || in_last);
    assign w_pop    = out_valid && out_ready;

    // Holding word with the incoming pixel merged into its lane; this is both
    // the next holding value and the word pushed on a flush.
    always_comb begin
        w_word_data                  = r_hold;
        w_word_data[r_lane*N +: N]   = in_data;
        w_word_keep                  = r_keep;
        w_word_keep[r_lane]          = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane <= '0;
            r_hold <= '0;
            r_keep <= '0;
        end else if (w_accept) begin
            if (w_flush) begin
                r_lane <= '0;
                r_hold <= '0;
                r_keep <= '0;
            end else begin
                r_lane <= r_lane + LW'(1);
                r_hold <= w_word_data;
                r_keep <= w_word_keep;
            end
        end
    end

    rop3_word_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_flush),
        .din   ({in_last, w_word_keep, w_word_data}),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count),
        .empty (w_empty)
    );

    assign out_valid                      = !w_empty;
    assign {out_last, out_keep, out_data} = w_head;

`ifdef ROP3_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [15:0] r_checksum;
    logic        r_cs_vld;
    logic [15:0] w_sum_next;

    assign w_sum_next = r_sum + 16'(in_data);

    // The result registers on the same edge that pushes the last word, so the
    // pulse lines up with the first cycle that word can be at the FIFO head.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum      <= '0;
            r_checksum <= '0;
            r_cs_vld   <= 1'b0;
        end else begin
            r_cs_vld <= 1'b0;
            if (w_accept) begin
                if (in_last) begin
                    r_checksum <= w_sum_next;
                    r_cs_vld   <= 1'b1;
                    r_sum      <= '0;
                end else begin
                    r_sum <= w_sum_next;
                end
            end
        end
    end

    assign checksum       = r_checksum;
    assign checksum_valid = r_cs_vld;
`else
    assign checksum       = '0;
    assign checksum_valid = 1'b0;
`endif

endmodule

// File: tb/tb_rop3_result_packer.sv
module tb_rop3_result_packer;
    import rop3_pkg::*;

    localparam int N     = ROP3_N;
    localparam int PACK  = ROP3_PACK;
    localparam int DEPTH = ROP3_DEPTH;
`ifdef ROP3_CHECKSUM_EN
    localparam bit CS_ON = 1'b1;
`else
    localparam bit CS_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [N-1:0]        in_data;
    logic                in_last;
    logic                in_ready;
    logic                out_valid;
    logic [N*PACK-1:0]   out_data;
    logic [PACK-1:0]     out_keep;
    logic                out_last;
    logic                out_ready;
    logic [15:0]         checksum;
    logic                checksum_valid;

    always #5 clk = ~clk;

    rop3_result_packer #(.N(N), .PACK(PACK), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_last        (in_last),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_keep       (out_keep),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .checksum       (checksum),
        .checksum_valid (checksum_valid)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pixels of the word being built, running frame sum.
    rop3_entry_t     exp_q[$];
    rop3_entry_t     got_q[$];
    logic [15:0]     exp_cs[$];
    logic [15:0]     got_cs[$];
    byte unsigned    m_px[$];
    int unsigned     m_sum = 0;
    int              n_acc = 0;
    int              stall_cycles = 0;

    // Capture every transferred word and every checksum pulse.
    always @(negedge clk) begin
        if (out_valid && out_ready) got_q.push_back({out_last, out_keep, out_data});
        if (checksum_valid) got_cs.push_back(checksum);
    end

    task automatic model_reset();
        m_px.delete();
        m_sum = 0;
    endtask

    task automatic model_accept(input logic [7:0] d, input bit l);
        rop3_entry_t       e;
        logic [N*PACK-1:0] w;
        m_px.push_back(d);
        m_sum += d;
        n_acc++;
        if (m_px.size() == PACK || l) begin
            e = '0;
            e.last = l;
            foreach (m_px[i]) begin
                w = m_px[i];
                e.data = e.data | (w << (N * i));
                e.keep[i] = 1'b1;
            end
            exp_q.push_back(e);
            m_px.delete();
        end
        if (l) begin
            if (CS_ON) exp_cs.push_back(16'(m_sum));
            m_sum = 0;
        end
    endtask

    task automatic push_px(input logic [7:0] d, input bit l);
        int waited = 0;
        bit done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done && waited < 300) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
                model_accept(d, l);
            end else begin
                waited++;
            end
        end
        stall_cycles += waited;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: pixel %h not accepted, in_ready=%b", d, in_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b need 0", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data: got %h need 0", out_data); end
        n_checks++; if (out_keep !== '0) begin n_fail++; $display("FAIL rst_out_keep: got %b need 0", out_keep); end
        n_checks++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b need 0", out_last); end
        n_checks++; if (checksum !== 16'h0) begin n_fail++; $display("FAIL rst_checksum: got %h need 0", checksum); end
        n_checks++; if (checksum_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cs_valid: got %b need 0", checksum_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b need 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        out_ready = 1'b1;
        push_px(8'h11, 0); push_px(8'h22, 0); push_px(8'h33, 0); push_px(8'h44, 1);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid_latency: got %b need 1", out_valid); end
        n_checks++; if (out_data !== 32'h44332211) begin n_fail++; $display("FAIL full_data: got %h need 44332211", out_data); end
        n_checks++; if (out_keep !== 4'b1111) begin n_fail++; $display("FAIL full_keep: got %b need 1111", out_keep); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL full_last: got %b need 1", out_last); end
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_cs.delete(); exp_cs.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_partial();
        out_ready = 1'b1;
        push_px(8'hAA, 0); push_px(8'hBB, 1);
        @(negedge clk);
        n_checks++; if (out_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL partial_data: got %h need 0000bbaa", out_data); end
        n_checks++; if (out_keep !== 4'b0011) begin n_fail++; $display("FAIL partial_keep: got %b need 0011", out_keep); end
        n_checks++; if (out_last !== 1'b1) begin n_fail++; $display("FAIL partial_last: got %b need 1", out_last); end
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL partial_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL partial_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_cs.delete(); exp_cs.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) push_px(8'(i), 0);
            end
            begin
                int cyc = 0;
                while (in_ready && cyc < 200) begin @(negedge clk); cyc++; end
                n_checks++; if (cyc >= 200) begin n_fail++; $display("FAIL bp_ready_drop: in_ready never fell after %0d cycles", cyc); end
                n_checks++; if (n_acc != 4 * PACK) begin n_fail++; $display("FAIL bp_accepted: got %0d pixels before stall need %0d", n_acc, 4 * PACK); end
                n_checks++; if (out_data !== 32'h03020100) begin n_fail++; $display("FAIL bp_head: got %h need 03020100", out_data); end
                repeat (4) @(negedge clk);
                n_checks++; if (out_data !== 32'h03020100 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold: got %h valid %b need 03020100 valid 1", out_data, out_valid); end
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full: in_ready got %b need 0", in_ready); end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete(); exp_q.delete(); got_cs.delete(); exp_cs.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        stall_cycles = 0;
        for (int i = 0; i < 48; i++)
            push_px(8'($urandom), (i == 47) || ($urandom_range(0, 7) == 0));
        n_checks++; if (stall_cycles != 0) begin n_fail++; $display("FAIL b2b_stalls: got %0d stall cycles need 0", stall_cycles); end
        repeat (4) @(negedge clk);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (got_cs.size() != exp_cs.size()) begin n_fail++; $display("FAIL b2b_cs_count: got %0d pulses need %0d", got_cs.size(), exp_cs.size()); end
        foreach (exp_cs[i]) if (i < got_cs.size()) begin
            n_checks++; if (got_cs[i] !== exp_cs[i]) begin n_fail++; $display("FAIL b2b_cs[%0d]: got %h need %h", i, got_cs[i], exp_cs[i]); end
        end
        got_q.delete(); exp_q.delete(); got_cs.delete(); exp_cs.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_checksum();
        out_ready = 1'b1;
        push_px(8'hFF, 0); push_px(8'hFF, 0); push_px(8'hFF, 0); push_px(8'hFF, 1);
        @(negedge clk);
        n_checks++; if (checksum_valid !== CS_ON) begin n_fail++; $display("FAIL cs_pulse: got %b need %b", checksum_valid, CS_ON); end
        n_checks++; if (checksum !== (CS_ON ? 16'h03FC : 16'h0)) begin n_fail++; $display("FAIL cs_frame1: got %h need %h", checksum, CS_ON ? 16'h03FC : 16'h0); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cs_word_visible: out_valid got %b need 1", out_valid); end
        @(negedge clk);
        n_checks++; if (checksum_valid !== 1'b0) begin n_fail++; $display("FAIL cs_pulse_width: got %b need 0", checksum_valid); end
        @(posedge clk); #1;
        push_px(8'h01, 1);
        @(negedge clk);
        n_checks++; if (checksum !== (CS_ON ? 16'h0001 : 16'h0)) begin n_fail++; $display("FAIL cs_frame2: got %h need %h", checksum, CS_ON ? 16'h0001 : 16'h0); end
        repeat (3) @(negedge clk);
        n_checks++; if (got_cs.size() != exp_cs.size()) begin n_fail++; $display("FAIL cs_count: got %0d pulses need %0d", got_cs.size(), exp_cs.size()); end
        foreach (exp_cs[i]) if (i < got_cs.size()) begin
            n_checks++; if (got_cs[i] !== exp_cs[i]) begin n_fail++; $display("FAIL cs_value[%0d]: got %h need %h", i, got_cs[i], exp_cs[i]); end
        end
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL cs_words: got %0d words need %0d", got_q.size(), exp_q.size()); end
        got_q.delete(); exp_q.delete(); got_cs.delete(); exp_cs.delete();
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        out_ready = 1'b1;
        push_px(8'h55, 0); push_px(8'h66, 0);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b need 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b need 0", out_valid); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mid_rst_emitted: got %0d words need 0", got_q.size()); end
        @(posedge clk); #1;
        push_px(8'h01, 0); push_px(8'h02, 0); push_px(8'h03, 0); push_px(8'h04, 1);
        @(negedge clk);
        n_checks++; if (out_data !== 32'h04030201) begin n_fail++; $display("FAIL mid_data: got %h need 04030201", out_data); end
        n_checks++; if (out_keep !== 4'b1111) begin n_fail++; $display("FAIL mid_keep: got %b need 1111", out_keep); end
        repeat (3) @(negedge clk);
        n_checks++; if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_count: got %0d words need %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            n_checks++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL mid_word[%0d]: got %h need %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++; if (got_cs.size() != exp_cs.size()) begin n_fail++; $display("FAIL mid_cs_count: got %0d pulses need %0d", got_cs.size(), exp_cs.size()); end
        foreach (exp_cs[i]) if (i < got_cs.size()) begin
            n_checks++; if (got_cs[i] !== exp_cs[i]) begin n_fail++; $display("FAIL mid_cs[%0d]: got %h need %h", i, got_cs[i], exp_cs[i]); end
        end
        got_q.delete(); exp_q.delete(); got_cs.delete(); exp_cs.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_back_to_back();
        test_checksum();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time, %0d checks made", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
